// File: rtl/uart_mem_loader.sv
// ============================================================================
// Module   : uart_mem_loader
// Brief    : 8N1 UART receiver that packs bytes little-endian into 32-bit
//            words and writes them to consecutive memory addresses from 0.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_mem_loader #(
    parameter int CLKS_PER_BIT = 434,
    parameter int DEPTH        = 3000,
    parameter int ADDR_W       = 12,
    parameter int IDLE_TIMEOUT = 50000
) (
    input  logic              CLOCK_50,
    input  logic              reset,
    input  logic              uart_rx,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [7:0]        rx_byte,
    output logic              rx_valid,
    output logic [ADDR_W-1:0] word_count,
    output logic              frame_err,
    output logic              full,
    output logic              load_done
);

    localparam int TMR_W  = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDLE_W = $clog2(IDLE_TIMEOUT + 1);

    localparam logic [TMR_W-1:0]  HALF_BIT  = TMR_W'(CLKS_PER_BIT / 2);
    localparam logic [TMR_W-1:0]  LAST_TICK = TMR_W'(CLKS_PER_BIT - 1);
    localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
    localparam logic [ADDR_W-1:0] DEPTH_C   = ADDR_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic                sync1;
    logic                sync2;
    logic                rx;
    logic [TMR_W-1:0]    timer;
    logic [2:0]          bit_idx;
    logic [7:0]          shift;
    logic                err_wait;
    logic [1:0]          lane;
    logic [23:0]         word_buf;
    logic [IDLE_W-1:0]   idle_cnt;
    logic                done_flag;

    logic                timer_clr;
    logic                bit_clr;
    logic                bit_sample;
    logic                accept;
    logic                ferr_set;
    logic                err_wait_set;
    logic                err_wait_clr;
    logic                timeout;
    logic                do_write;
    logic [31:0]         write_data;

    assign rx = sync2;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
        end else begin
            sync1 <= uart_rx;
            sync2 <= sync1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next   = state;
        timer_clr    = 1'b0;
        bit_clr      = 1'b0;
        bit_sample   = 1'b0;
        accept       = 1'b0;
        ferr_set     = 1'b0;
        err_wait_set = 1'b0;
        err_wait_clr = 1'b0;
        case (state)
            IDLE: begin
                if (!rx) begin
                    state_next = START;
                    timer_clr  = 1'b1;
                end
            end
            START: begin
                if (timer == HALF_BIT) begin
                    if (rx) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        timer_clr  = 1'b1;
                        bit_clr    = 1'b1;
                    end
                end
            end
            DATA: begin
                if (timer == LAST_TICK) begin
                    bit_sample = 1'b1;
                    timer_clr  = 1'b1;
                    if (bit_idx == 3'd7) begin
                        state_next = STOP;
                    end
                end
            end
            STOP: begin
                // After a bad stop bit, park here until the line idles high.
                if (err_wait) begin
                    if (rx) begin
                        state_next   = IDLE;
                        err_wait_clr = 1'b1;
                    end
                end else if (timer == LAST_TICK) begin
                    if (rx) begin
                        accept     = 1'b1;
                        state_next = IDLE;
                    end else begin
                        ferr_set     = 1'b1;
                        err_wait_set = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            timer    <= '0;
            bit_idx  <= '0;
            shift    <= '0;
            err_wait <= 1'b0;
        end else begin
            timer <= timer_clr ? '0 : timer + TMR_W'(1);
            if (bit_clr) begin
                bit_idx <= '0;
            end else if (bit_sample) begin
                bit_idx <= bit_idx + 3'd1;
            end
            if (bit_sample) begin
                shift <= {rx, shift[7:1]};
            end
            if (err_wait_set) begin
                err_wait <= 1'b1;
            end else if (err_wait_clr) begin
                err_wait <= 1'b0;
            end
        end
    end

    // A byte landing in the timeout cycle wins; the idle period restarts.
    assign timeout = (idle_cnt == IDLE_LAST) && !done_flag && !accept && !rx_valid
                     && ((word_count != '0) || (lane != 2'd0));

    assign do_write   = !full && ((accept && (lane == 2'd3)) || (timeout && (lane != 2'd0)));
    assign write_data = accept ? {shift, word_buf} : {8'h00, word_buf};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            rx_byte    <= '0;
            rx_valid   <= 1'b0;
            word_count <= '0;
            frame_err  <= 1'b0;
            full       <= 1'b0;
            load_done  <= 1'b0;
            lane       <= '0;
            word_buf   <= '0;
            idle_cnt   <= '0;
            done_flag  <= 1'b0;
        end else begin
            mem_we    <= 1'b0;
            load_done <= 1'b0;
            rx_valid  <= accept;
            if (accept) begin
                rx_byte <= shift;
            end
            if (ferr_set) begin
                frame_err <= 1'b1;
            end

            if (rx_valid) begin
                idle_cnt  <= '0;
                done_flag <= 1'b0;
            end else begin
                if (idle_cnt != IDLE_LAST) begin
                    idle_cnt <= idle_cnt + IDLE_W'(1);
                end
                if (timeout) begin
                    done_flag <= 1'b1;
                end
            end

            if (accept) begin
                lane <= lane + 2'd1;
                case (lane)
                    2'd0:    word_buf[7:0]   <= shift;
                    2'd1:    word_buf[15:8]  <= shift;
                    2'd2:    word_buf[23:16] <= shift;
                    default: word_buf        <= '0;
                endcase
            end else if (timeout) begin
                load_done <= 1'b1;
                lane      <= '0;
                word_buf  <= '0;
            end

            if (do_write) begin
                mem_we     <= 1'b1;
                mem_addr   <= word_count;
                mem_wdata  <= write_data;
                word_count <= word_count + ADDR_W'(1);
                if ((word_count + ADDR_W'(1)) == DEPTH_C) begin
                    full <= 1'b1;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_uart_mem_loader.sv
// ============================================================================
// Module   : tb_uart_mem_loader
// Brief    : Self-checking bench for uart_mem_loader with a word-level model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_mem_loader;

    localparam int CPB     = 8;
    localparam int TMO     = 400;
    localparam int AW      = 12;

    logic          clk;
    logic          rst;
    logic          uart_rx;

    logic          mem_we,    f_mem_we;
    logic [AW-1:0] mem_addr,  f_mem_addr;
    logic [31:0]   mem_wdata, f_mem_wdata;
    logic [7:0]    rx_byte,   f_rx_byte;
    logic          rx_valid,  f_rx_valid;
    logic [AW-1:0] word_count, f_word_count;
    logic          frame_err, f_frame_err;
    logic          full,      f_full;
    logic          load_done, f_load_done;

    int checks = 0;
    int errors = 0;

    logic [AW+31:0] wq[$];
    logic [AW+31:0] fwq[$];
    logic [7:0]     bq[$];
    logic [7:0]     fbq[$];
    int             done_cnt;
    int             fdone_cnt;

    uart_mem_loader #(.CLKS_PER_BIT(CPB), .DEPTH(3000), .ADDR_W(AW), .IDLE_TIMEOUT(TMO)) dut (
        .CLOCK_50(clk), .reset(rst), .uart_rx(uart_rx),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .word_count(word_count),
        .frame_err(frame_err), .full(full), .load_done(load_done)
    );

    uart_mem_loader #(.CLKS_PER_BIT(CPB), .DEPTH(2), .ADDR_W(AW), .IDLE_TIMEOUT(TMO)) dut_f (
        .CLOCK_50(clk), .reset(rst), .uart_rx(uart_rx),
        .mem_we(f_mem_we), .mem_addr(f_mem_addr), .mem_wdata(f_mem_wdata),
        .rx_byte(f_rx_byte), .rx_valid(f_rx_valid), .word_count(f_word_count),
        .frame_err(f_frame_err), .full(f_full), .load_done(f_load_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (mem_we)      wq.push_back({mem_addr, mem_wdata});
        if (rx_valid)    bq.push_back(rx_byte);
        if (load_done)   done_cnt++;
        if (f_mem_we)    fwq.push_back({f_mem_addr, f_mem_wdata});
        if (f_rx_valid)  fbq.push_back(f_rx_byte);
        if (f_load_done) fdone_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        uart_rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        wq.delete(); fwq.delete(); bq.delete(); fbq.delete();
        done_cnt  = 0;
        fdone_cnt = 0;
        repeat (5) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit, input int gap);
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            uart_rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        uart_rx = stop_bit;
        repeat (CPB) @(negedge clk);
        uart_rx = 1'b1;
        repeat (gap) @(negedge clk);
    endtask

    // Reference: bytes packed little-endian, tail flushed zero-padded, capped at depth.
    task automatic model_writes(input logic [7:0] bytes[$], input int depth,
                                output logic [AW+31:0] exp_q[$]);
        logic [31:0] word;
        int          n;
        exp_q.delete();
        word = 32'h0;
        n    = bytes.size();
        for (int i = 0; i < n; i++) begin
            word = word | (32'(bytes[i]) << (8 * (i % 4)));
            if ((i % 4 == 3) || (i == n - 1)) begin
                if (exp_q.size() < depth)
                    exp_q.push_back({AW'(exp_q.size()), word});
                word = 32'h0;
            end
        end
    endtask

    task automatic test_reset();
        logic [63:0] outs, fouts;
        rst     = 1'b1;
        uart_rx = 1'b0;
        repeat (6) @(negedge clk);
        outs  = 64'({mem_we, mem_addr, mem_wdata, rx_byte, rx_valid, word_count, frame_err, full, load_done});
        fouts = 64'({f_mem_we, f_mem_addr, f_mem_wdata, f_rx_byte, f_rx_valid, f_word_count,
                     f_frame_err, f_full, f_load_done});
        checks++;
        if (outs !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", outs);
        end
        checks++;
        if (fouts !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs_small: got %h expected 0", fouts);
        end
        rst     = 1'b0;
        uart_rx = 1'b1;
        bq.delete(); wq.delete();
        repeat (200) @(negedge clk);
        checks++;
        if (bq.size() != 0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_quiet: got %0d bytes ferr=%b expected 0 bytes ferr=0", bq.size(), frame_err);
        end
    endtask

    task automatic test_word();
        logic [7:0] exp_b[$] = '{8'h78, 8'h56, 8'h34, 8'h12};
        do_reset();
        foreach (exp_b[i]) send_byte(exp_b[i], 1'b1, 5);
        repeat (10) @(negedge clk);
        checks++;
        if (bq.size() != 4) begin
            errors++;
            $display("FAIL word_rx_count: got %0d expected 4", bq.size());
        end else begin
            foreach (exp_b[i]) begin
                checks++;
                if (bq[i] !== exp_b[i]) begin
                    errors++;
                    $display("FAIL word_rx_byte%0d: got %h expected %h", i, bq[i], exp_b[i]);
                end
            end
        end
        checks++;
        if (wq.size() != 1 || wq[0] !== {12'd0, 32'h12345678}) begin
            errors++;
            $display("FAIL word_write: got n=%0d first=%h expected n=1 %h", wq.size(),
                     (wq.size() > 0) ? wq[0] : '0, {12'd0, 32'h12345678});
        end
        checks++;
        if (word_count !== 12'd1) begin
            errors++;
            $display("FAIL word_count: got %0d expected 1", word_count);
        end
    endtask

    task automatic test_glitch();
        do_reset();
        @(negedge clk);
        uart_rx = 1'b0;
        repeat (3) @(negedge clk);
        uart_rx = 1'b1;
        repeat (100) @(negedge clk);
        checks++;
        if (bq.size() != 0 || frame_err !== 1'b0) begin
            errors++;
            $display("FAIL glitch_quiet: got %0d bytes ferr=%b expected 0 bytes ferr=0", bq.size(), frame_err);
        end
        send_byte(8'hC3, 1'b1, 10);
        checks++;
        if (bq.size() != 1 || rx_byte !== 8'hC3) begin
            errors++;
            $display("FAIL glitch_recover: got n=%0d byte=%h expected n=1 byte=c3", bq.size(), rx_byte);
        end
    endtask

    task automatic test_frame_err();
        logic [7:0] good[$];
        logic [AW+31:0] exp_q[$];
        do_reset();
        send_byte(8'hA5, 1'b0, 20);
        checks++;
        if (frame_err !== 1'b1 || bq.size() != 0) begin
            errors++;
            $display("FAIL ferr_set: got ferr=%b n=%0d expected ferr=1 n=0", frame_err, bq.size());
        end
        for (int i = 0; i < 4; i++) good.push_back(8'($urandom));
        foreach (good[i]) send_byte(good[i], 1'b1, $urandom_range(0, 20));
        repeat (10) @(negedge clk);
        model_writes(good, 3000, exp_q);
        checks++;
        if (wq.size() != 1 || wq[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL ferr_next_word: got n=%0d first=%h expected n=1 %h", wq.size(),
                     (wq.size() > 0) ? wq[0] : '0, exp_q[0]);
        end
        checks++;
        if (frame_err !== 1'b1) begin
            errors++;
            $display("FAIL ferr_sticky: got %b expected 1", frame_err);
        end
    endtask

    task automatic test_timeout();
        do_reset();
        send_byte(8'h11, 1'b1, 5);
        send_byte(8'h22, 1'b1, 5);
        repeat (TMO + 100) @(negedge clk);
        checks++;
        if (done_cnt != 1) begin
            errors++;
            $display("FAIL tmo_done: got %0d pulses expected 1", done_cnt);
        end
        checks++;
        if (wq.size() != 1 || wq[0] !== {12'd0, 32'h00002211}) begin
            errors++;
            $display("FAIL tmo_flush: got n=%0d first=%h expected n=1 %h", wq.size(),
                     (wq.size() > 0) ? wq[0] : '0, {12'd0, 32'h00002211});
        end
        checks++;
        if (word_count !== 12'd1) begin
            errors++;
            $display("FAIL tmo_count: got %0d expected 1", word_count);
        end
        repeat (2 * TMO) @(negedge clk);
        checks++;
        if (done_cnt != 1 || wq.size() != 1) begin
            errors++;
            $display("FAIL tmo_once: got pulses=%0d writes=%0d expected 1 and 1", done_cnt, wq.size());
        end
        send_byte(8'h33, 1'b1, 5);
        repeat (TMO + 100) @(negedge clk);
        checks++;
        if (wq.size() != 2 || wq[1] !== {12'd1, 32'h00000033}) begin
            errors++;
            $display("FAIL tmo_fresh_word: got n=%0d expected second write %h", wq.size(), {12'd1, 32'h00000033});
        end
    endtask

    task automatic test_full();
        logic [7:0] bytes[$];
        logic [AW+31:0] exp_q[$];
        do_reset();
        for (int i = 0; i < 12; i++) bytes.push_back(8'($urandom));
        foreach (bytes[i]) send_byte(bytes[i], 1'b1, $urandom_range(0, 15));
        repeat (TMO + 100) @(negedge clk);
        model_writes(bytes, 2, exp_q);
        checks++;
        if (fwq.size() != 2) begin
            errors++;
            $display("FAIL full_writes: got %0d expected 2", fwq.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (fwq[i] !== exp_q[i]) begin
                    errors++;
                    $display("FAIL full_write%0d: got %h expected %h", i, fwq[i], exp_q[i]);
                end
            end
        end
        checks++;
        if (f_full !== 1'b1 || f_word_count !== 12'd2) begin
            errors++;
            $display("FAIL full_flag: got full=%b wc=%0d expected full=1 wc=2", f_full, f_word_count);
        end
        checks++;
        if (fbq.size() != 12 || fbq[11] !== bytes[11]) begin
            errors++;
            $display("FAIL full_rx_continues: got n=%0d expected n=12", fbq.size());
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 3; it++) begin
            logic [7:0] good[$];
            logic [AW+31:0] exp_q[$];
            int n, err_pos;
            do_reset();
            n       = $urandom_range(5, 14);
            err_pos = $urandom_range(0, n);
            for (int i = 0; i < n; i++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (i == err_pos) begin
                    send_byte(b, 1'b0, 20);
                end else begin
                    good.push_back(b);
                    send_byte(b, 1'b1, $urandom_range(0, 30));
                end
            end
            repeat (TMO + 100) @(negedge clk);
            model_writes(good, 3000, exp_q);
            checks++;
            if (wq.size() != exp_q.size()) begin
                errors++;
                $display("FAIL rand%0d_nwrites: got %0d expected %0d", it, wq.size(), exp_q.size());
            end else begin
                foreach (exp_q[i]) begin
                    checks++;
                    if (wq[i] !== exp_q[i]) begin
                        errors++;
                        $display("FAIL rand%0d_write%0d: got %h expected %h", it, i, wq[i], exp_q[i]);
                    end
                end
            end
            checks++;
            if (word_count !== AW'(exp_q.size()) || done_cnt != 1 ||
                frame_err !== (err_pos < n) || bq.size() != good.size()) begin
                errors++;
                $display("FAIL rand%0d_status: got wc=%0d done=%0d ferr=%b nb=%0d expected wc=%0d done=1 ferr=%b nb=%0d",
                         it, word_count, done_cnt, frame_err, bq.size(), exp_q.size(), (err_pos < n), good.size());
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        uart_rx  = 1'b0;
        done_cnt = 0;
        fdone_cnt = 0;
        test_reset();
        test_word();
        test_glitch();
        test_frame_err();
        test_timeout();
        test_full();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
- Writer side of the unified program/data memory. The board top only reads this memory, one word per heartbeat, and shows it on the LEDs.
- This block receives a byte stream over an 8N1 UART pin, packs every 4 bytes little-endian into a 32-bit word, and issues single-cycle writes to consecutive memory addresses starting at 0.
- The host can reload the memory image without rebuilding the bitstream.

Parameters:
- CLKS_PER_BIT, 434, CLOCK_50 cycles per UART bit (50 MHz / 115200). The bench overrides this to 8.
- DEPTH, 3000, number of 32-bit words in the target memory.
- ADDR_W, 12, width of the memory address and of the word counter.
- IDLE_TIMEOUT, 50000, idle cycles after the last byte before load_done pulses.

Ports:
- CLOCK_50  in  1  system clock; every register updates on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- uart_rx  in  1  serial input; idles high; asynchronous to CLOCK_50.
- mem_we  out  1  one-cycle memory write strobe.
- mem_addr  out  ADDR_W  word address for the write.
- mem_wdata  out  32  word to be written.
- rx_byte  out  8  last correctly framed byte, intended for LEDG display.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- word_count  out  ADDR_W  number of words written since reset.
- frame_err  out  1  sticky flag: a stop bit was sampled low.
- full  out  1  sticky flag: DEPTH words have been written.
- load_done  out  1  one-cycle pulse at the end of a load.

Behaviour:
- Reset (asynchronous): every output is 0; FSM is IDLE; byte lane is 0; synchroniser flops are 1.
- uart_rx passes through a 2-flop synchroniser. All references to "rx" below mean the synchronised signal.
- Bit timer counts 0 to CLKS_PER_BIT-1.
- FSM states: IDLE, START, DATA, STOP.
- IDLE:
  - On rx=0, go to START and clear the bit timer.
- START:
  - At timer = CLKS_PER_BIT/2 (integer divide), sample rx.
  - rx=1: glitch; return to IDLE with no output activity.
  - rx=0: go to DATA, clear the timer and the bit index.
- DATA:
  - Every CLKS_PER_BIT cycles, shift rx into the shift register, LSB first.
  - After bit index 7, go to STOP.
- STOP:
  - Sample rx CLKS_PER_BIT cycles after the last data sample.
  - rx=1: byte accepted.
  - rx=0: set frame_err; discard the byte; the byte lane does not advance. Return to IDLE once rx returns high.
- Accepted-byte latency: in the cycle after the stop sample, rx_byte updates and rx_valid=1 for exactly one cycle. FSM is then IDLE.
- Word packing:
  - Lane 0 goes to mem_wdata[7:0], lane 3 to [31:24].
  - The lane counter is 2 bits and wraps from 3 to 0.
- Write on the 4th byte, in the same cycle as rx_valid:
  - mem_we=1 for one cycle.
  - mem_addr = word_count before increment.
  - mem_wdata = the complete word.
  - mem_addr and mem_wdata hold their values until the next write.
- word_count increments in that same cycle.
- Full handling:
  - When word_count reaches DEPTH, full=1.
  - Later bytes still update rx_byte and rx_valid, but mem_we never asserts again.
  - word_count saturates at DEPTH; there is no address wrap-around.
- Idle timeout:
  - The idle counter resets on every rx_valid.
  - If word_count is nonzero or the lane is nonzero, and IDLE_TIMEOUT cycles pass without a new byte, pulse load_done.
  - A partial word (lane not 0) is flushed in that same cycle: mem_we=1, unused upper bytes written as 0, word_count increments (subject to full).
  - The lane then resets to 0. At most one load_done pulse per idle period.
- Start edge on the load_done cycle: the start edge is honoured. The next byte begins a fresh word at the current word_count.
- Reset during a frame: the partial byte and the partial word are lost, and the FSM restarts in IDLE. The memory contents are not this block's concern.

Test Plan:
1. Reset held with uart_rx=0 -> all outputs 0. After reset releases and rx returns high, no rx_valid.
2. CLKS_PER_BIT=8; send bytes 0x78, 0x56, 0x34, 0x12 -> rx_valid ×4 carrying those values. One mem_we with mem_addr=0, mem_wdata=0x12345678. word_count=1.
3. Low glitch of 3 cycles on uart_rx -> FSM returns to IDLE; no rx_valid, no frame_err.
4. Byte 0xA5 sent with stop bit 0 -> frame_err=1 and stays set. No rx_valid. The next good 4 bytes still write to address 0.
5. Send 0x11, 0x22, then idle for IDLE_TIMEOUT cycles -> one load_done pulse. mem_we with mem_addr=0, mem_wdata=0x00002211. word_count=1.
6. DEPTH=2; send 12 bytes -> exactly 2 mem_we pulses (addresses 0 and 1). full=1, word_count=2. rx_valid keeps pulsing for the remaining 4 bytes.
